affine_scan_ctrl: RTL

Sequencer for the 2D affine address scan: addr = offset + x*x_stride + y*y_stride, with x as the inner loop and y as the outer loop.
- Accepts one configuration per job over a valid/ready handshake and latches it.
- Emits exactly x_max*y_max addresses on a backpressured valid/ready stream, flags the last one, pulses done, and supports abort.
- Sits between the job/config issuer and the memory request port; replaces the free-running scan chain with a start/stop-controlled one.

---
 rtl/affine_scan_pkg.sv | 22 ++
 rtl/affine_scan_ctrl_if.sv | 32 +++
 rtl/affine_dim_counter.sv | 67 ++++++
 rtl/affine_scan_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/affine_scan_pkg.sv
// Shared types and widths for the 2D affine address scan sequencer.
package affine_scan_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 32;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]     offset;
        logic [CNT_WIDTH-1:0] x_max;
        logic [WIDTH-1:0]     x_stride;
        logic [CNT_WIDTH-1:0] y_max;
        logic [WIDTH-1:0]     y_stride;
    } scan_cfg_t;

endpackage

// File: rtl/affine_scan_ctrl_if.sv
// Config channel plus address stream of the affine scan sequencer.
interface affine_scan_ctrl_if;
    import affine_scan_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [WIDTH-1:0]     cfg_offset;
    logic [CNT_WIDTH-1:0] cfg_x_max;
    logic [WIDTH-1:0]     cfg_x_stride;
    logic [CNT_WIDTH-1:0] cfg_y_max;
    logic [WIDTH-1:0]     cfg_y_stride;
    logic                 abort;
    logic                 addr_valid;
    logic                 addr_ready;
    logic [WIDTH-1:0]     addr;
    logic                 addr_last;
    logic                 busy;
    logic                 done;

    modport slave (
        input  cfg_valid, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride,
        input  abort, addr_ready,
        output cfg_ready, addr_valid, addr, addr_last, busy, done
    );

    modport master (
        output cfg_valid, cfg_offset, cfg_x_max, cfg_x_stride, cfg_y_max, cfg_y_stride,
        output abort, addr_ready,
        input  cfg_ready, addr_valid, addr, addr_last, busy, done
    );

endinterface

// File: rtl/affine_dim_counter.sv
// One scan dimension: loop counter plus stride accumulator, with look-ahead
// of the post-edge values so the top can register the next address directly.
module affine_dim_counter
    import affine_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 step,
    input  logic [CNT_WIDTH-1:0] max,
    input  logic [WIDTH-1:0]     stride,
    output logic [CNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]     acc,
    output logic                 wrap,
    output logic [CNT_WIDTH-1:0] count_nxt,
    output logic [WIDTH-1:0]     acc_nxt,
    output logic                 wrap_nxt
);

    logic [CNT_WIDTH-1:0] count_r;
    logic [WIDTH-1:0]     acc_r;
    logic [CNT_WIDTH-1:0] last_idx_s;
    logic [CNT_WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0]     acc_nxt_s;

    assign last_idx_s = max - CNT_ONE;

    // Next count/accumulator: clear beats step, step wraps back to zero at max-1.
    always_comb begin
        count_nxt_s = count_r;
        acc_nxt_s   = acc_r;
        if (clear) begin
            count_nxt_s = {CNT_WIDTH{1'b0}};
            acc_nxt_s   = {WIDTH{1'b0}};
        end else if (step) begin
            if (count_r == last_idx_s) begin
                count_nxt_s = {CNT_WIDTH{1'b0}};
                acc_nxt_s   = {WIDTH{1'b0}};
            end else begin
                count_nxt_s = count_r + CNT_ONE;
                acc_nxt_s   = acc_r + stride;
            end
        end else begin
            count_nxt_s = count_r;
            acc_nxt_s   = acc_r;
        end
    end

    // Counter and accumulator state.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            acc_r   <= acc_nxt_s;
        end
    end

    assign count     = count_r;
    assign acc       = acc_r;
    assign wrap      = (count_r == last_idx_s);
    assign count_nxt = count_nxt_s;
    assign acc_nxt   = acc_nxt_s;
    assign wrap_nxt  = (count_nxt_s == last_idx_s);

endmodule

// File: rtl/affine_scan_ctrl.sv
// Start/stop controlled 2D affine scan: addr = offset + x*x_stride + y*y_stride,
// x inner, y outer, streamed on a backpressured valid/ready port.
module affine_scan_ctrl
    import affine_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    affine_scan_ctrl_if.slave  bus
);

    state_t               state_r;
    scan_cfg_t            cfg_r;
    scan_cfg_t            cfg_in_s;
    logic                 addr_valid_r;
    logic [WIDTH-1:0]     addr_r;
    logic                 addr_last_r;
    logic                 done_r;

    logic                 cfg_hs_s;
    logic                 hs_s;
    logic                 hs_last_s;
    logic                 clear_s;
    logic                 cfg_zero_s;
    logic                 cfg_single_s;

    logic [CNT_WIDTH-1:0] x_count_s, y_count_s, x_count_nxt_s, y_count_nxt_s;
    logic [WIDTH-1:0]     x_acc_s, y_acc_s, x_acc_nxt_s, y_acc_nxt_s;
    logic                 x_wrap_s, y_wrap_s, x_wrap_nxt_s, y_wrap_nxt_s;

    assign cfg_in_s = '{offset:   bus.cfg_offset,
                        x_max:    bus.cfg_x_max,
                        x_stride: bus.cfg_x_stride,
                        y_max:    bus.cfg_y_max,
                        y_stride: bus.cfg_y_stride};

    assign bus.cfg_ready = (state_r == IDLE) && !rst;
    assign cfg_hs_s      = bus.cfg_valid && bus.cfg_ready;
    assign cfg_zero_s    = (bus.cfg_x_max == {CNT_WIDTH{1'b0}}) || (bus.cfg_y_max == {CNT_WIDTH{1'b0}});
    assign cfg_single_s  = (bus.cfg_x_max == CNT_ONE) && (bus.cfg_y_max == CNT_ONE);

    assign hs_s      = addr_valid_r && bus.addr_ready;
    assign hs_last_s = hs_s && addr_last_r;
    // Counters sit at zero whenever no job runs, so a new job starts from origin.
    assign clear_s   = (state_r != RUN) || hs_last_s || bus.abort;

    affine_dim_counter u_x (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .step      (hs_s),
        .max       (cfg_r.x_max),
        .stride    (cfg_r.x_stride),
        .count     (x_count_s),
        .acc       (x_acc_s),
        .wrap      (x_wrap_s),
        .count_nxt (x_count_nxt_s),
        .acc_nxt   (x_acc_nxt_s),
        .wrap_nxt  (x_wrap_nxt_s)
    );

    affine_dim_counter u_y (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .step      (hs_s && x_wrap_s),
        .max       (cfg_r.y_max),
        .stride    (cfg_r.y_stride),
        .count     (y_count_s),
        .acc       (y_acc_s),
        .wrap      (y_wrap_s),
        .count_nxt (y_count_nxt_s),
        .acc_nxt   (y_acc_nxt_s),
        .wrap_nxt  (y_wrap_nxt_s)
    );

    // Sequencer FSM with registered stream outputs and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cfg_r        <= '0;
            addr_valid_r <= 1'b0;
            addr_r       <= {WIDTH{1'b0}};
            addr_last_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r       <= 1'b0;
                    addr_valid_r <= 1'b0;
                    addr_last_r  <= 1'b0;
                    if (cfg_hs_s) begin
                        cfg_r <= cfg_in_s;
                        if (cfg_zero_s) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r      <= RUN;
                            addr_valid_r <= 1'b1;
                            addr_r       <= bus.cfg_offset;
                            addr_last_r  <= cfg_single_s;
                        end
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    // Completion outranks abort when both land on the final beat.
                    if (hs_last_s) begin
                        state_r      <= IDLE;
                        addr_valid_r <= 1'b0;
                        addr_last_r  <= 1'b0;
                        done_r       <= 1'b1;
                    end else if (bus.abort) begin
                        state_r      <= IDLE;
                        addr_valid_r <= 1'b0;
                        addr_last_r  <= 1'b0;
                    end else if (hs_s) begin
                        addr_r      <= cfg_r.offset + x_acc_nxt_s + y_acc_nxt_s;
                        addr_last_r <= x_wrap_nxt_s && y_wrap_nxt_s;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    addr_valid_r <= 1'b0;
                    addr_last_r  <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.addr_valid = addr_valid_r;
    assign bus.addr       = addr_r;
    assign bus.addr_last  = addr_last_r;
    assign bus.done       = done_r;
    assign bus.busy       = (state_r == RUN);

endmodule
